// File: rtl/tone_arbiter.sv
// Fixed-priority tone scheduler: one square-wave generator shared by NUM_REQ
// requesters (index 0 highest). Lower-priority tones can be preempted.
// Each tone plays a fixed number of cycles, then an optional silent gap follows.
module tone_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int PERIOD_W   = 20,
  parameter int DUR_W      = 28,
  parameter int GAP_CYCLES = 250000,
  parameter int AMPLITUDE  = 100000000
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*PERIOD_W-1:0]  req_half_period,
  input  logic [NUM_REQ*DUR_W-1:0]     req_duration,
  input  logic                         mute,
  input  logic                         audio_out_allowed,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic [NUM_REQ-1:0]           abort,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   active_id,
  output logic [31:0]                  left_channel_audio_out,
  output logic [31:0]                  right_channel_audio_out,
  output logic                         write_audio_out
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [31:0] AMP_POS = 32'(AMPLITUDE);
  localparam logic [31:0] AMP_NEG = 32'(-AMPLITUDE);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t                state_reg;
  logic [PERIOD_W-1:0]   hp_reg;
  logic [DUR_W-1:0]      dur_last_reg;   // duration-1, with a zero duration already folded to 1
  logic [PERIOD_W-1:0]   phase_reg;
  logic                  sign_reg;
  logic [DUR_W-1:0]      dur_cnt_reg;
  logic [GAP_W-1:0]      gap_cnt_reg;
  logic [NUM_REQ-1:0]    grant_reg;
  logic [NUM_REQ-1:0]    done_reg;
  logic [NUM_REQ-1:0]    abort_reg;
  logic                  busy_reg;
  logic [ID_W-1:0]       active_id_reg;
  logic [31:0]           sample_reg;

  // Per-requester parameter fields, unpacked from the flat input buses
  logic [PERIOD_W-1:0]   hp_field  [NUM_REQ];
  logic [DUR_W-1:0]      dur_field [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign hp_field[gi]  = req_half_period[gi*PERIOD_W +: PERIOD_W];
      assign dur_field[gi] = req_duration[gi*DUR_W +: DUR_W];
    end
  endgenerate

  logic                  sel_any;
  logic [ID_W-1:0]       sel_idx;
  logic [NUM_REQ-1:0]    sel_onehot;

  // Priority encoder: lowest-indexed active request wins
  always_comb begin
    sel_any    = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_any = 1'b1;
        sel_idx = ID_W'(i);
      end
    end
    sel_onehot[sel_idx] = sel_any;
  end

  logic [PERIOD_W-1:0]   sel_hp;
  logic [DUR_W-1:0]      sel_dur_last;
  logic [31:0]           start_sample_next;
  logic                  phase_wrap;
  logic [PERIOD_W-1:0]   phase_next;
  logic                  sign_next;
  logic [31:0]           play_sample_next;
  logic                  last_cycle;
  logic                  preempt;

  // Next-cycle tone values: fresh start for a new grant, or the running waveform
  always_comb begin
    sel_hp            = hp_field[sel_idx];
    sel_dur_last      = (dur_field[sel_idx] == '0) ? '0 : dur_field[sel_idx] - DUR_W'(1);
    start_sample_next = (sel_hp != '0 && !mute) ? AMP_POS : 32'd0;

    phase_wrap = (hp_reg != '0) && (phase_reg == hp_reg - PERIOD_W'(1));
    phase_next = (hp_reg == '0 || phase_wrap) ? '0 : phase_reg + PERIOD_W'(1);
    sign_next  = phase_wrap ? ~sign_reg : sign_reg;
    play_sample_next = 32'd0;
    if (hp_reg != '0 && !mute) begin
      play_sample_next = sign_next ? AMP_NEG : AMP_POS;
    end

    last_cycle = (dur_cnt_reg == dur_last_reg);
    preempt    = sel_any && (sel_idx < active_id_reg);
  end

  // Sequencer FSM with all outputs registered; completion beats preemption
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg     <= IDLE;
      hp_reg        <= '0;
      dur_last_reg  <= '0;
      phase_reg     <= '0;
      sign_reg      <= 1'b0;
      dur_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      grant_reg     <= '0;
      done_reg      <= '0;
      abort_reg     <= '0;
      busy_reg      <= 1'b0;
      active_id_reg <= '0;
      sample_reg    <= '0;
    end else begin
      grant_reg <= '0;
      done_reg  <= '0;
      abort_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (sel_any) begin
            state_reg     <= PLAY;
            grant_reg     <= sel_onehot;
            hp_reg        <= sel_hp;
            dur_last_reg  <= sel_dur_last;
            phase_reg     <= '0;
            sign_reg      <= 1'b0;
            dur_cnt_reg   <= '0;
            active_id_reg <= sel_idx;
            busy_reg      <= 1'b1;
            sample_reg    <= start_sample_next;
          end else begin
            busy_reg   <= 1'b0;
            sample_reg <= '0;
          end
        end
        PLAY: begin
          if (last_cycle) begin
            done_reg[active_id_reg] <= 1'b1;
            sample_reg  <= '0;
            phase_reg   <= '0;
            sign_reg    <= 1'b0;
            dur_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            if (GAP_CYCLES == 0) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= GAP;
              busy_reg  <= 1'b1;
            end
          end else if (preempt) begin
            abort_reg[active_id_reg] <= 1'b1;
            grant_reg     <= sel_onehot;
            hp_reg        <= sel_hp;
            dur_last_reg  <= sel_dur_last;
            phase_reg     <= '0;
            sign_reg      <= 1'b0;
            dur_cnt_reg   <= '0;
            active_id_reg <= sel_idx;
            sample_reg    <= start_sample_next;
          end else begin
            phase_reg   <= phase_next;
            sign_reg    <= sign_next;
            dur_cnt_reg <= dur_cnt_reg + DUR_W'(1);
            sample_reg  <= play_sample_next;
          end
        end
        GAP: begin
          sample_reg <= '0;
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign grant                   = grant_reg;
  assign done                    = done_reg;
  assign abort                   = abort_reg;
  assign busy                    = busy_reg;
  assign active_id               = active_id_reg;
  assign left_channel_audio_out  = sample_reg;
  assign right_channel_audio_out = sample_reg;
  assign write_audio_out         = audio_out_allowed;

endmodule

// File: tb/tb_tone_arbiter.sv
// Self-checking bench for tone_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the scheduler.
module tb_tone_arbiter;

  localparam int NR  = 4;
  localparam int PW  = 20;
  localparam int DW  = 28;
  localparam int GAP = 2;
  localparam int AMP = 100000000;
  localparam logic [31:0] POS = 32'(AMP);
  localparam logic [31:0] NEG = 32'(-AMP);

  logic              CLOCK_50 = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*PW-1:0]  req_half_period = '0;
  logic [NR*DW-1:0]  req_duration = '0;
  logic              mute = 1'b0;
  logic              audio_out_allowed = 1'b1;
  logic [NR-1:0]     grant, done, abort;
  logic              busy;
  logic [1:0]        active_id;
  logic [31:0]       left_channel_audio_out, right_channel_audio_out;
  logic              write_audio_out;

  tone_arbiter #(
    .NUM_REQ(NR), .PERIOD_W(PW), .DUR_W(DW), .GAP_CYCLES(GAP), .AMPLITUDE(AMP)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .req(req),
    .req_half_period(req_half_period),
    .req_duration(req_duration),
    .mute(mute),
    .audio_out_allowed(audio_out_allowed),
    .grant(grant),
    .done(done),
    .abort(abort),
    .busy(busy),
    .active_id(active_id),
    .left_channel_audio_out(left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out),
    .write_audio_out(write_audio_out)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int passed = 0;

  // Behavioural model: mode 0 idle, 1 playing, 2 silent gap
  int          m_mode = 0;
  int          m_owner = 0;
  int          m_hp = 0;
  int          m_dur = 1;
  int          m_k = 0;     // index of the PLAY cycle currently under way
  int          m_gap = 0;   // gap cycles already finished
  logic [3:0]  e_grant = '0, e_done = '0, e_abort = '0;
  logic        e_busy = 1'b0;
  logic [1:0]  e_id = '0;
  logic [31:0] e_sample = '0;

  function automatic logic [31:0] tone_sample(input int hp, input int k, input logic mt);
    if (hp == 0 || mt) return 32'd0;
    return (((k / hp) % 2) == 1) ? NEG : POS;
  endfunction

  function automatic int hp_of(input int i);
    return int'(req_half_period[i*PW +: PW]);
  endfunction

  function automatic int dur_of(input int i);
    return int'(req_duration[i*DW +: DW]);
  endfunction

  task automatic model_step();
    int low;
    low = -1;
    for (int i = NR - 1; i >= 0; i--) if (req[i]) low = i;
    e_grant = '0; e_done = '0; e_abort = '0;
    if (reset) begin
      m_mode = 0; m_owner = 0; m_k = 0; m_gap = 0;
      e_busy = 1'b0; e_id = '0; e_sample = '0;
    end else if (m_mode == 1 && m_k == m_dur - 1) begin
      e_done = 4'(1 << m_owner);
      e_sample = '0;
      m_mode = (GAP > 0) ? 2 : 0;
      m_gap = 0;
      e_busy = (GAP > 0);
    end else if ((m_mode == 0 && low >= 0) || (m_mode == 1 && low >= 0 && low < m_owner)) begin
      if (m_mode == 1) e_abort = 4'(1 << m_owner);
      m_mode = 1; m_owner = low; m_k = 0;
      m_hp = hp_of(low);
      m_dur = (dur_of(low) == 0) ? 1 : dur_of(low);
      e_grant = 4'(1 << low);
      e_id = 2'(low);
      e_busy = 1'b1;
      e_sample = tone_sample(m_hp, 0, mute);
    end else if (m_mode == 1) begin
      m_k++;
      e_sample = tone_sample(m_hp, m_k, mute);
    end else if (m_mode == 2) begin
      m_gap++;
      e_sample = '0;
      if (m_gap == GAP) begin
        m_mode = 0;
        e_busy = 1'b0;
      end
    end else begin
      e_sample = '0;
      e_busy = 1'b0;
    end
  endtask

  // One clock: model sees the same inputs as the DUT edge; outputs sampled on the falling edge
  task automatic tick();
    @(posedge CLOCK_50);
    model_step();
    @(negedge CLOCK_50);
  endtask

  task automatic set_tone(input int i, input int hp, input int dur);
    req_half_period[i*PW +: PW] = PW'(hp);
    req_duration[i*DW +: DW] = DW'(dur);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    checks++; if (busy !== 1'b0) $display("FAIL %s_idle_timeout busy=%b required 0", tag, busy); else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    audio_out_allowed = 1'b0;
    repeat (3) tick();
    checks++; if (grant !== 4'b0 || done !== 4'b0 || abort !== 4'b0) $display("FAIL reset_pulses got g=%b d=%b a=%b required 0", grant, done, abort); else passed++;
    checks++; if (busy !== 1'b0 || active_id !== 2'd0) $display("FAIL reset_busy_id got busy=%b id=%0d required 0/0", busy, active_id); else passed++;
    checks++; if (left_channel_audio_out !== 32'd0 || right_channel_audio_out !== 32'd0) $display("FAIL reset_samples got %h/%h required 0", left_channel_audio_out, right_channel_audio_out); else passed++;
    checks++; if (write_audio_out !== 1'b0) $display("FAIL reset_write_lo got %b required 0", write_audio_out); else passed++;
    audio_out_allowed = 1'b1;
    #1;
    checks++; if (write_audio_out !== 1'b1) $display("FAIL reset_write_hi got %b required 1", write_audio_out); else passed++;
    reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || grant !== 4'b0) $display("FAIL idle_quiet got busy=%b grant=%b required 0", busy, grant); else passed++;
  endtask

  task automatic test_basic();
    logic [31:0] pat [10];
    pat = '{POS, POS, POS, NEG, NEG, NEG, POS, POS, POS, NEG};
    set_tone(2, 3, 10);
    req = 4'b0100;
    tick();
    checks++; if (grant !== 4'b0100 || busy !== 1'b1 || active_id !== 2'd2) $display("FAIL basic_grant got g=%b busy=%b id=%0d required 0100/1/2", grant, busy, active_id); else passed++;
    req = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      checks++; if (left_channel_audio_out !== pat[k] || right_channel_audio_out !== pat[k]) $display("FAIL basic_sample k=%0d got %h/%h required %h", k, left_channel_audio_out, right_channel_audio_out, pat[k]); else passed++;
      if (k < 9) tick();
    end
    checks++; if (done !== 4'b0) $display("FAIL basic_early_done got %b required 0000", done); else passed++;
    tick();
    checks++; if (done !== 4'b0100 || left_channel_audio_out !== 32'd0 || busy !== 1'b1) $display("FAIL basic_done got d=%b s=%h busy=%b required 0100/0/1", done, left_channel_audio_out, busy); else passed++;
    tick();
    checks++; if (done !== 4'b0 || left_channel_audio_out !== 32'd0 || busy !== 1'b1) $display("FAIL basic_gap got d=%b s=%h busy=%b required 0000/0/1", done, left_channel_audio_out, busy); else passed++;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL basic_idle got busy=%b required 0", busy); else passed++;
  endtask

  task automatic test_simultaneous();
    set_tone(1, 2, 4);
    set_tone(3, 5, 3);
    req = 4'b1010;
    tick();
    checks++; if (grant !== 4'b0010 || active_id !== 2'd1) $display("FAIL simul_grant got g=%b id=%0d required 0010/1", grant, active_id); else passed++;
    req = 4'b1000;
    repeat (3) tick();
    checks++; if (done !== 4'b0 || grant !== 4'b0) $display("FAIL simul_play got d=%b g=%b required 0000/0000", done, grant); else passed++;
    tick();
    checks++; if (done !== 4'b0010) $display("FAIL simul_done got %b required 0010", done); else passed++;
    tick();
    tick();
    checks++; if (busy !== 1'b0 || grant !== 4'b0) $display("FAIL simul_idle got busy=%b g=%b required 0/0000", busy, grant); else passed++;
    tick();
    checks++; if (grant !== 4'b1000 || active_id !== 2'd3) $display("FAIL simul_regrant got g=%b id=%0d required 1000/3", grant, active_id); else passed++;
    req = 4'b0000;
    wait_idle("simul");
  endtask

  task automatic test_preempt();
    set_tone(2, 4, 100);
    req = 4'b0100;
    tick();
    checks++; if (grant !== 4'b0100) $display("FAIL pre_first_grant got %b required 0100", grant); else passed++;
    req = 4'b0000;
    repeat (19) tick();
    set_tone(0, 3, 6);
    req = 4'b0001;
    tick();
    checks++; if (abort !== 4'b0100 || grant !== 4'b0001 || done !== 4'b0) $display("FAIL pre_swap got a=%b g=%b d=%b required 0100/0001/0000", abort, grant, done); else passed++;
    checks++; if (left_channel_audio_out !== POS || active_id !== 2'd0 || busy !== 1'b1) $display("FAIL pre_restart got s=%h id=%0d busy=%b required %h/0/1", left_channel_audio_out, active_id, busy, POS); else passed++;
    req = 4'b0000;
    repeat (3) tick();
    checks++; if (left_channel_audio_out !== NEG) $display("FAIL pre_toggle got %h required %h", left_channel_audio_out, NEG); else passed++;
    repeat (2) tick();
    checks++; if (done !== 4'b0) $display("FAIL pre_early_done got %b required 0000", done); else passed++;
    tick();
    checks++; if (done !== 4'b0001 || abort !== 4'b0) $display("FAIL pre_done got d=%b a=%b required 0001/0000", done, abort); else passed++;
    wait_idle("preempt");
  endtask

  task automatic test_collision();
    set_tone(1, 2, 8);
    req = 4'b0010;
    tick();
    checks++; if (grant !== 4'b0010) $display("FAIL coll_grant got %b required 0010", grant); else passed++;
    req = 4'b0000;
    repeat (7) tick();
    set_tone(0, 2, 2);
    req = 4'b0001;
    tick();
    checks++; if (done !== 4'b0010 || abort !== 4'b0 || grant !== 4'b0) $display("FAIL coll_done got d=%b a=%b g=%b required 0010/0000/0000", done, abort, grant); else passed++;
    tick();
    tick();
    checks++; if (grant !== 4'b0 || busy !== 1'b0) $display("FAIL coll_gap got g=%b busy=%b required 0000/0", grant, busy); else passed++;
    tick();
    checks++; if (grant !== 4'b0001) $display("FAIL coll_late_grant got %b required 0001", grant); else passed++;
    req = 4'b0000;
    wait_idle("collision");
  endtask

  task automatic test_edges();
    set_tone(3, 0, 5);
    req = 4'b1000;
    tick();
    req = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      checks++; if (left_channel_audio_out !== 32'd0 || busy !== 1'b1) $display("FAIL rest_sample k=%0d got s=%h busy=%b required 0/1", k, left_channel_audio_out, busy); else passed++;
      tick();
    end
    checks++; if (done !== 4'b1000) $display("FAIL rest_done got %b required 1000", done); else passed++;
    wait_idle("rest");
    set_tone(2, 3, 0);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    checks++; if (left_channel_audio_out !== POS || grant !== 4'b0100) $display("FAIL dur0_play got s=%h g=%b required %h/0100", left_channel_audio_out, grant, POS); else passed++;
    tick();
    checks++; if (done !== 4'b0100) $display("FAIL dur0_done got %b required 0100", done); else passed++;
    wait_idle("dur0");
    mute = 1'b1;
    set_tone(1, 2, 4);
    req = 4'b0010;
    tick();
    req = 4'b0000;
    checks++; if (grant !== 4'b0010) $display("FAIL mute_grant got %b required 0010", grant); else passed++;
    for (int k = 0; k < 4; k++) begin
      checks++; if (left_channel_audio_out !== 32'd0 || right_channel_audio_out !== 32'd0) $display("FAIL mute_sample k=%0d got %h required 0", k, left_channel_audio_out); else passed++;
      tick();
    end
    checks++; if (done !== 4'b0010) $display("FAIL mute_done got %b required 0010", done); else passed++;
    mute = 1'b0;
    wait_idle("mute");
  endtask

  task automatic test_reset_mid();
    set_tone(2, 3, 50);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    repeat (5) tick();
    checks++; if (busy !== 1'b1) $display("FAIL rmid_playing got busy=%b required 1", busy); else passed++;
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || left_channel_audio_out !== 32'd0 || active_id !== 2'd0) $display("FAIL rmid_cleared got busy=%b s=%h id=%0d required 0/0/0", busy, left_channel_audio_out, active_id); else passed++;
    checks++; if (done !== 4'b0 || abort !== 4'b0) $display("FAIL rmid_pulses got d=%b a=%b required 0000/0000", done, abort); else passed++;
    reset = 1'b0;
    tick();
    checks++; if (done !== 4'b0 || abort !== 4'b0 || busy !== 1'b0) $display("FAIL rmid_after got d=%b a=%b busy=%b required 0/0/0", done, abort, busy); else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 15) == 0) begin
            set_tone(i, int'($urandom_range(0, 5)), int'($urandom_range(0, 12)));
            req[i] = 1'b1;
          end
        end else if (grant[i] ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 19) == 0)) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 49) == 0) mute = ~mute;
      audio_out_allowed = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 399) == 0);
      tick();
      checks++; if (grant !== e_grant) $display("FAIL rand_grant cyc=%0d got %b required %b", c, grant, e_grant); else passed++;
      checks++; if (done !== e_done) $display("FAIL rand_done cyc=%0d got %b required %b", c, done, e_done); else passed++;
      checks++; if (abort !== e_abort) $display("FAIL rand_abort cyc=%0d got %b required %b", c, abort, e_abort); else passed++;
      checks++; if (busy !== e_busy) $display("FAIL rand_busy cyc=%0d got %b required %b", c, busy, e_busy); else passed++;
      checks++; if (active_id !== e_id) $display("FAIL rand_id cyc=%0d got %0d required %0d", c, active_id, e_id); else passed++;
      checks++; if (left_channel_audio_out !== e_sample) $display("FAIL rand_left cyc=%0d got %h required %h", c, left_channel_audio_out, e_sample); else passed++;
      checks++; if (right_channel_audio_out !== e_sample) $display("FAIL rand_right cyc=%0d got %h required %h", c, right_channel_audio_out, e_sample); else passed++;
      checks++; if (write_audio_out !== audio_out_allowed) $display("FAIL rand_write cyc=%0d got %b required %b", c, write_audio_out, audio_out_allowed); else passed++;
    end
    reset = 1'b0;
    req = '0;
    mute = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_preempt();
    test_collision();
    test_edges();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
